// File: rtl/bit_population_counter_pipe.sv
// Streaming popcount (ones or zeros per beat) through a registered adder tree,
// with a saturating per-packet running total and valid/ready flow control.
module bit_population_counter_pipe #(
  parameter  int WIDTH     = 64,
  parameter  int REG_EVERY = 2,
  parameter  int ACC_WIDTH = 16,
  localparam int CNT_W     = $clog2(WIDTH + 1),
  localparam int LVL       = $clog2(WIDTH),
  localparam int LAT       = 1 + (LVL + REG_EVERY - 1) / REG_EVERY
) (
  input  logic                 clk_i,
  input  logic                 srst_n_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 data_mode_i,
  input  logic                 data_last_i,
  input  logic                 data_val_i,
  output logic                 data_rdy_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 sat_o,
  output logic                 last_o,
  output logic                 out_val_o,
  input  logic                 out_rdy_i
);

  localparam int N = 1 << LVL;

  logic           en;
  logic [N-1:0]   leaf;
  logic [LAT-1:0] vld;
  logic [LAT-1:0] lst;
  logic           tail_vld_in;
  logic           tail_lst_in;

  // One enable for every stage: the whole pipe freezes while the output waits.
  assign en         = out_rdy_i || !out_val_o;
  assign data_rdy_o = srst_n_i && en;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    leaf              = '0;
    leaf[WIDTH-1:0]   = data_i ^ {WIDTH{data_mode_i}};
  end

  // Level l holds N>>l partial sums of l+1 bits each; level 0 is the leaf bits.
  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    localparam int NL = N >> l;
    localparam int WL = l + 1;
    logic [NL*WL-1:0] sum;
    logic [NL*WL-1:0] node;

    if (l == 0) begin : g_leaf
      assign sum = leaf;
    end else begin : g_add
      for (genvar i = 0; i < NL; i++) begin : g_node
        assign sum[i*WL +: WL] = {1'b0, g_lvl[l-1].node[(2*i)*(WL-1) +: WL-1]}
                               + {1'b0, g_lvl[l-1].node[(2*i+1)*(WL-1) +: WL-1]};
      end
    end

    if (l == 0 || (l % REG_EVERY) == 0 || l == LVL) begin : g_reg
      // NOTE: the tree registers are reset (not left free-running) because
      // cnt_o, which is the last of them, must read 0 out of reset.
      always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
          node <= '0;
        end else if (en) begin
          node <= sum;
        end
      end
    end else begin : g_comb
      assign node = sum;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every stage samples the previous stage's pre-edge value.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      vld <= '0;
      lst <= '0;
    end else if (en) begin
      vld[0] <= data_val_i;
      lst[0] <= data_last_i;
      for (int k = 1; k < LAT; k++) begin
        vld[k] <= vld[k-1];
        lst[k] <= lst[k-1];
      end
    end
  end

  if (LAT == 1) begin : g_tail_direct
    assign tail_vld_in = data_val_i;
    assign tail_lst_in = data_last_i;
  end else begin : g_tail_piped
    assign tail_vld_in = vld[LAT-2];
    assign tail_lst_in = lst[LAT-2];
  end

  assign out_val_o = vld[LAT-1];
  assign last_o    = lst[LAT-1];
  assign cnt_o     = g_lvl[LVL].node[CNT_W-1:0];

  logic [CNT_W-1:0]     cnt_next;
  logic [ACC_WIDTH:0]   raw_sum;
  logic [ACC_WIDTH-1:0] sum_next;
  logic                 sat_next;
  logic [ACC_WIDTH-1:0] acc;
  logic                 sat_acc;

  assign cnt_next = g_lvl[LVL].sum[CNT_W-1:0];
  assign raw_sum  = {1'b0, acc} + {{(ACC_WIDTH + 1 - CNT_W){1'b0}}, cnt_next};
  assign sum_next = raw_sum[ACC_WIDTH] ? '1 : raw_sum[ACC_WIDTH-1:0];
  assign sat_next = sat_acc | raw_sum[ACC_WIDTH];

  // The running total advances only when a real beat enters the output stage.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      acc     <= '0;
      sat_acc <= 1'b0;
      sum_o   <= '0;
      sat_o   <= 1'b0;
    end else if (en && tail_vld_in) begin
      sum_o <= sum_next;
      sat_o <= sat_next;
      if (tail_lst_in) begin
        acc     <= '0;
        sat_acc <= 1'b0;
      end else begin
        acc     <= sum_next;
        sat_acc <= sat_next;
      end
    end
  end

endmodule
